// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types for the scheduler and the pixel generators.
package fb_pkg;
  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 180;
  localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  typedef logic [15:0] rgb565_t;
  typedef logic [15:0] pix_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DRAW,
    ST_WAIT_SWAP
  } fb_sched_state_t;
endpackage

// File: rtl/fb_scheduler_rr_arbiter.sv
// Round-robin arbiter: grant is combinational from the valid vector; the pointer
// remembers the last granted requester and only moves when a grant is given.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [N-1:0]                    valid_i,
  output logic [N-1:0]                    grant_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] gidx_o,
  output logic                            xfer_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] idx_w;
  logic          found;

  // Scan starting just after the last winner so every requester gets a turn.
  always_comb begin
    grant_o = '0;
    gidx_o  = last_q;
    found   = 1'b0;
    idx_w   = '0;
    if (en_i) begin
      for (int k = 1; k <= N; k++) begin
        idx_w = PW'((int'(last_q) + k) % N);
        if (!found && valid_i[idx_w]) begin
          found          = 1'b1;
          grant_o[idx_w] = 1'b1;
          gidx_o         = idx_w;
        end
      end
    end
    xfer_o = found;
  end

  // Reset to N-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= PW'(N - 1);
    end else if (found) begin
      last_q <= gidx_o;
    end
  end
endmodule

// File: rtl/fb_scheduler.sv
// Framebuffer write scheduler: clears the back buffer, arbitrates pixel writes
// round-robin, then swaps front/back on vsync.
module fb_scheduler #(
  parameter int          NUM_REQ     = 2,
  parameter int          FB_WIDTH    = fb_pkg::FB_WIDTH,
  parameter int          FB_HEIGHT   = fb_pkg::FB_HEIGHT,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     frame_start_in,
  input  logic                     draw_done_in,
  input  logic                     vsync_in,
  input  logic [NUM_REQ-1:0]       req_valid_in,
  input  logic [NUM_REQ-1:0][15:0] req_addr_in,
  input  logic [NUM_REQ-1:0][15:0] req_color_in,
  output logic [NUM_REQ-1:0]       req_ready_out,
  output logic                     wr_en_out,
  output logic [16:0]              wr_addr_out,
  output logic [15:0]              wr_data_out,
  output logic                     front_sel_out,
  output logic                     swap_out,
  output logic                     oob_out,
  output logic                     busy_out
);
  import fb_pkg::*;

  localparam int        DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int        GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam pix_addr_t LAST  = pix_addr_t'(DEPTH - 1);

  fb_sched_state_t state_q, state_d;
  pix_addr_t       cnt_q, cnt_d;
  logic            front_q, front_d;
  logic            wr_en_q, wr_en_d;
  logic [16:0]     wr_addr_q, wr_addr_d;
  rgb565_t         wr_data_q, wr_data_d;
  logic            oob_q, oob_d;
  logic            swap_q, swap_d;

  logic [NUM_REQ-1:0] grant;
  logic [GW-1:0]      gidx;
  logic               xfer;
  pix_addr_t          sel_addr;
  rgb565_t            sel_color;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .en_i    (state_q == ST_DRAW),
    .valid_i (req_valid_in),
    .grant_o (grant),
    .gidx_o  (gidx),
    .xfer_o  (xfer)
  );

  assign sel_addr  = req_addr_in[gidx];
  assign sel_color = req_color_in[gidx];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    front_d   = front_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    oob_d     = 1'b0;
    swap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_in) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {~front_q, cnt_q};
        wr_data_d = CLEAR_COLOR;
        cnt_d     = cnt_q + 16'd1;
        if (cnt_q == LAST) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        // Out-of-range pixels are still handshaken so a requester never stalls on them.
        if (xfer) begin
          if ({1'b0, sel_addr} < 17'(DEPTH)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {~front_q, sel_addr};
            wr_data_d = sel_color;
          end else begin
            oob_d = 1'b1;
          end
        end
        if (draw_done_in) state_d = ST_WAIT_SWAP;
      end
      ST_WAIT_SWAP: begin
        if (vsync_in) begin
          front_d = ~front_q;
          swap_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      front_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      oob_q     <= 1'b0;
      swap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      front_q   <= front_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      oob_q     <= oob_d;
      swap_q    <= swap_d;
    end
  end

  assign req_ready_out = grant;
  assign wr_en_out     = wr_en_q;
  assign wr_addr_out   = wr_addr_q;
  assign wr_data_out   = wr_data_q;
  assign front_sel_out = front_q;
  assign swap_out      = swap_q;
  assign oob_out       = oob_q;
  assign busy_out      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fb_scheduler.sv
// Randomized bench for fb_scheduler against a frame-level reference model
// (small framebuffer so several full frames fit in a short run).
module tb_fb_scheduler;
  localparam int          NR    = 2;
  localparam int          W     = 40;
  localparam int          H     = 10;
  localparam int          DEPTH = W * H;
  localparam logic [15:0] CLR   = 16'h0000;

  logic                clk = 1'b0;
  logic                rst, fs, dd, vs;
  logic [NR-1:0]       rv;
  logic [NR-1:0][15:0] ra, rc;
  logic [NR-1:0]       rdy;
  logic                wr_en, front_sel, swap, oob, busy;
  logic [16:0]         wr_addr;
  logic [15:0]         wr_data;

  always #5 clk = ~clk;

  fb_scheduler #(
    .NUM_REQ(NR), .FB_WIDTH(W), .FB_HEIGHT(H), .CLEAR_COLOR(CLR)
  ) dut (
    .clk_in(clk), .rst_in(rst), .frame_start_in(fs), .draw_done_in(dd), .vsync_in(vs),
    .req_valid_in(rv), .req_addr_in(ra), .req_color_in(rc), .req_ready_out(rdy),
    .wr_en_out(wr_en), .wr_addr_out(wr_addr), .wr_data_out(wr_data),
    .front_sel_out(front_sel), .swap_out(swap), .oob_out(oob), .busy_out(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: frame phase, clear progress, displayed buffer, last winner.
  typedef enum int {M_IDLE, M_CLEAR, M_DRAW, M_WAIT} mph_t;
  mph_t        ph    = M_IDLE;
  int          cnt   = 0;
  bit          front = 1'b0;
  int          last  = NR - 1;
  logic        e_en, e_oob, e_swap;
  logic [16:0] e_addr;
  logic [15:0] e_data;
  logic [NR-1:0] e_gnt;

  function automatic int pick(input logic [NR-1:0] v, input int lst);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (lst + k) % NR;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic rand_reqs(input int span);
    rv = NR'($urandom);
    for (int i = 0; i < NR; i++) begin
      ra[i] = 16'($urandom_range(span - 1));
      rc[i] = 16'($urandom);
    end
  endtask

  // Inputs are set just after a rising edge; this checks the combinational grant,
  // advances the model, and checks the registered outputs after the next edge.
  task automatic cycle();
    int g;
    #1;
    g = (ph == M_DRAW && !rst) ? pick(rv, last) : -1;
    e_gnt = '0;
    if (g >= 0) e_gnt[g] = 1'b1;
    if (!rst) chk("req_ready", rdy, e_gnt);
    e_en = 1'b0; e_oob = 1'b0; e_swap = 1'b0;
    if (rst) begin
      ph = M_IDLE; front = 1'b0; last = NR - 1; e_addr = '0; e_data = '0;
    end else begin
      case (ph)
        M_IDLE: if (fs) begin ph = M_CLEAR; cnt = 0; end
        M_CLEAR: begin
          e_en = 1'b1; e_addr = {~front, 16'(cnt)}; e_data = CLR;
          cnt++;
          if (cnt == DEPTH) ph = M_DRAW;
        end
        M_DRAW: begin
          if (g >= 0) begin
            last = g;
            if (int'(ra[g]) < DEPTH) begin
              e_en = 1'b1; e_addr = {~front, ra[g]}; e_data = rc[g];
            end else e_oob = 1'b1;
          end
          if (dd) ph = M_WAIT;
        end
        M_WAIT: if (vs) begin front = ~front; e_swap = 1'b1; ph = M_IDLE; end
        default: ph = M_IDLE;
      endcase
    end
    @(posedge clk); #1;
    chk("wr_en", wr_en, e_en);
    if (e_en || rst) begin
      chk("wr_addr", wr_addr, e_addr);
      chk("wr_data", wr_data, e_data);
    end
    chk("oob", oob, e_oob);
    chk("swap", swap, e_swap);
    chk("front_sel", front_sel, front);
    chk("busy", busy, ph != M_IDLE);
  endtask

  task automatic run_frame(input int draw_cycles, input bit dd_with_vs);
    fs = 1'b1; cycle(); fs = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dd = ($urandom_range(7) == 0); fs = ($urandom_range(7) == 0);
      rand_reqs(DEPTH + 8); cycle();
    end
    dd = 1'b0; fs = 1'b0;
    for (int i = 0; i < draw_cycles; i++) begin
      fs = ($urandom_range(9) == 0); vs = ($urandom_range(9) == 0);
      rand_reqs(DEPTH + 8); cycle();
    end
    fs = 1'b0;
    dd = 1'b1; vs = dd_with_vs; rand_reqs(DEPTH); cycle();
    dd = 1'b0; vs = 1'b0;
    repeat (3) begin rand_reqs(DEPTH); cycle(); end
    vs = 1'b1; cycle(); vs = 1'b0;
    rv = '0; cycle();
  endtask

  initial begin
    rst = 1'b1; fs = 1'b0; dd = 1'b0; vs = 1'b0; rv = '0; ra = '0; rc = '0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;
    repeat (5) begin dd = 1'($urandom); vs = 1'($urandom); rand_reqs(DEPTH); cycle(); end
    dd = 1'b0; vs = 1'b0;

    // Frame 1: full clear with ignored noise, then directed arbitration cases.
    fs = 1'b1; cycle(); fs = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      dd = ($urandom_range(7) == 0); fs = ($urandom_range(7) == 0);
      rand_reqs(DEPTH + 8); cycle();
    end
    dd = 1'b0; fs = 1'b0;
    rv = 2'b11; ra[0] = 16'd100; ra[1] = 16'd200;
    repeat (8) begin rc[0] = 16'($urandom); rc[1] = 16'($urandom); cycle(); end
    rv = 2'b10; ra[1] = 16'(DEPTH); cycle();
    ra[1] = 16'(DEPTH - 1); cycle();
    rv = '0; cycle();
    for (int i = 0; i < 150; i++) begin
      fs = ($urandom_range(9) == 0); vs = ($urandom_range(9) == 0);
      rand_reqs(DEPTH + 8); cycle();
    end
    fs = 1'b0;
    dd = 1'b1; vs = 1'b1; rand_reqs(DEPTH); cycle();
    dd = 1'b0; vs = 1'b0;
    repeat (4) begin rand_reqs(DEPTH); cycle(); end
    vs = 1'b1; cycle(); vs = 1'b0;
    rv = '0; cycle();

    // Frame 2 aborted by reset during the clear.
    fs = 1'b1; cycle(); fs = 1'b0;
    repeat (50) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    repeat (3) cycle();

    run_frame(120, 1'b0);
    run_frame(80, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
